// File: rtl/circle_motion_ctrl.sv
// circle_motion_ctrl: button-driven position, colour and clamping of the OLED circle sprite
module circle_motion_ctrl #(
  parameter int TICK_DIV = 2_000_000,
  parameter int RADIUS   = 6,
  parameter int WIDTH    = 96,
  parameter int HEIGHT   = 64,
  parameter int START_X  = 48,
  parameter int START_Y  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btnU,
  input  logic        btnD,
  input  logic        btnL,
  input  logic        btnR,
  input  logic        btnC,
  output logic [6:0]  base_x,
  output logic [6:0]  base_y,
  output logic [15:0] colour,
  output logic        moving,
  output logic [2:0]  dir
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [6:0] MIN_X = 7'(RADIUS);
  localparam logic [6:0] MAX_X = 7'(WIDTH - 1 - RADIUS);
  localparam logic [6:0] MIN_Y = 7'(RADIUS);
  localparam logic [6:0] MAX_Y = 7'(HEIGHT - 1 - RADIUS);
  typedef enum logic [2:0] {STOP = 3'd0, UP = 3'd1, DOWN = 3'd2, LEFT = 3'd3, RIGHT = 3'd4} state_t;
  state_t state_q, state_d, req;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0] x_q, x_d, y_q, y_d;
  logic [15:0] col_q, col_d;
  logic [4:0] btn, btn_q, press;
  logic blocked, turn, step, at_limit;
  assign btn   = {btnC, btnU, btnD, btnL, btnR};
  assign press = btn & ~btn_q;
  // Next state: centre press beats direction changes, which beat the pending step
  always_comb begin
    req      = press[3] ? UP : press[2] ? DOWN : press[1] ? LEFT : press[0] ? RIGHT : STOP;
    blocked  = req == UP   ? y_q == MIN_Y :
               req == DOWN ? y_q == MAX_Y :
               req == LEFT ? x_q == MIN_X :
               req == RIGHT ? x_q == MAX_X : 1'b1;
    turn     = !press[4] && !blocked && req != state_q;
    step     = state_q != STOP && cnt_q == CW'(TICK_DIV - 1);
    state_d  = state_q;
    cnt_d    = (state_q == STOP || step) ? '0 : cnt_q + 1'b1;
    x_d      = x_q;
    y_d      = y_q;
    col_d    = col_q;
    at_limit = 1'b0;
    if (press[4]) begin
      state_d = STOP;
      cnt_d   = '0;
      col_d   = col_q == 16'h07E0 ? 16'hF800 :
                col_q == 16'hF800 ? 16'h001F :
                col_q == 16'h001F ? 16'hFFFF : 16'h07E0;
    end else if (turn) begin
      state_d = req;
      cnt_d   = '0;
    end else if (step) begin
      x_d      = state_q == LEFT ? x_q - 7'd1 : state_q == RIGHT ? x_q + 7'd1 : x_q;
      y_d      = state_q == UP ? y_q - 7'd1 : state_q == DOWN ? y_q + 7'd1 : y_q;
      at_limit = (state_q == UP && y_d == MIN_Y) || (state_q == DOWN && y_d == MAX_Y) ||
                 (state_q == LEFT && x_d == MIN_X) || (state_q == RIGHT && x_d == MAX_X);
      state_d  = at_limit ? STOP : state_q;
    end
  end
  // State, position, colour and button history registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= STOP;
      cnt_q   <= '0;
      x_q     <= 7'(START_X);
      y_q     <= 7'(START_Y);
      col_q   <= 16'h07E0;
      btn_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      btn_q   <= btn;
    end
  end
  assign base_x = x_q;
  assign base_y = y_q;
  assign colour = col_q;
  assign moving = state_q != STOP;
  assign dir    = state_q;
endmodule

// File: tb/tb_circle_motion_ctrl.sv
// tb_circle_motion_ctrl: scoreboard bench for circle_motion_ctrl with TICK_DIV=4
module tb_circle_motion_ctrl;
  logic clk, reset, btnU, btnD, btnL, btnR, btnC;
  logic [6:0] base_x, base_y;
  logic [15:0] colour;
  logic moving;
  logic [2:0] dir;
  circle_motion_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR), .btnC(btnC),
    .base_x(base_x), .base_y(base_y), .colour(colour), .moving(moving), .dir(dir)
  );
  typedef struct {
    int at;
    logic [6:0] x;
    logic [6:0] y;
    logic [15:0] col;
    logic [2:0] d;
    string nm;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int cyc = 0;
  int vectors = 0;
  int miss = 0;
  string scen = "init";
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required < 200000", $time);
    $fatal(1, "watchdog");
  end
  task automatic cmp(string nm, logic [6:0] x, logic [6:0] y, logic [15:0] col, logic [2:0] d);
    vectors++;
    if ({base_x, base_y, colour, moving, dir} !== {x, y, col, d != 3'd0, d}) begin
      miss++;
      $display("FAIL %s cyc %0d: got x=%0d y=%0d col=%h mv=%b dir=%0d, want x=%0d y=%0d col=%h mv=%b dir=%0d",
               nm, cyc, base_x, base_y, colour, moving, dir, x, y, col, d != 3'd0, d);
    end
  endtask
  // Monitor: each negedge, compare every expectation due at this cycle
  always @(negedge clk) begin
    cyc++;
    while (q.size() > 0 && q[0].at <= cyc) begin
      e = q.pop_front();
      if (e.at < cyc) begin
        vectors++;
        miss++;
        $display("FAIL %s: expectation for cyc %0d seen at cyc %0d", e.nm, e.at, cyc);
      end else cmp(e.nm, e.x, e.y, e.col, e.d);
    end
  end
  task automatic exp(int x, int y, logic [15:0] col, int d);
    q.push_back('{cyc + 1, 7'(x), 7'(y), col, 3'(d), scen});
  endtask
  task automatic cyc1();
    @(negedge clk);
    #1;
  endtask
  task automatic do_reset();
    {btnU, btnD, btnL, btnR, btnC} = '0;
    reset = 1'b1;
    cyc1();
    reset = 1'b0;
  endtask
  function automatic int imin(int a, int b);
    return a < b ? a : b;
  endfunction
  initial begin
    reset = 1'b0;
    {btnU, btnD, btnL, btnR, btnC} = '0;
    #1 reset = 1'b1;
    #1 cmp("reset_hold", 7'd48, 7'd32, 16'h07E0, 3'd0);
    cyc1();
    reset = 1'b0;
    scen = "after_reset";
    for (int o = 0; o < 3; o++) begin
      exp(48, 32, 16'h07E0, 0);
      cyc1();
    end
    scen = "right_pulse";
    for (int o = 0; o <= 8; o++) begin
      btnR = o == 0;
      exp(48 + o / 4, 32, 16'h07E0, 4);
      cyc1();
    end
    do_reset();
    scen = "right_held";
    for (int o = 0; o <= 20; o++) begin
      btnR = o < 20;
      btnL = o == 10;
      if (o < 10) exp(48 + o / 4, 32, 16'h07E0, 4);
      else exp(50 - (o - 10) / 4, 32, 16'h07E0, 3);
      cyc1();
    end
    do_reset();
    scen = "right_wall";
    for (int o = 0; o <= 192; o++) begin
      btnR = o == 0 || o == 186;
      exp(48 + imin(o / 4, 41), 32, 16'h07E0, o < 164 ? 4 : 0);
      cyc1();
    end
    do_reset();
    scen = "centre_colour";
    for (int o = 0; o <= 16; o++) begin
      btnR = o == 0;
      btnC = o == 2 || o == 5 || o == 8 || o == 11;
      exp(48, 32, o < 2 ? 16'h07E0 : o < 5 ? 16'hF800 : o < 8 ? 16'h001F : o < 11 ? 16'hFFFF : 16'h07E0,
          o < 2 ? 4 : 0);
      cyc1();
    end
    do_reset();
    scen = "up_left_same_cycle";
    for (int o = 0; o <= 110; o++) begin
      btnU = o == 0;
      btnL = o == 0;
      exp(48, 32 - imin(o / 4, 26), 16'h07E0, o < 104 ? 1 : 0);
      cyc1();
    end
    do_reset();
    scen = "left_on_step_edge";
    for (int o = 0; o <= 17; o++) begin
      btnU = o == 0;
      btnL = o == 8;
      if (o < 8) exp(48, 32 - o / 4, 16'h07E0, 1);
      else exp(48 - (o - 8) / 4, 31, 16'h07E0, 3);
      cyc1();
    end
    do_reset();
    scen = "pre_async_reset";
    for (int o = 0; o <= 5; o++) begin
      btnR = o == 0;
      exp(48 + o / 4, 32, 16'h07E0, 4);
      cyc1();
    end
    #1 reset = 1'b1;
    #1 cmp("async_reset", 7'd48, 7'd32, 16'h07E0, 3'd0);
    cyc1();
    reset = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) cyc1();
    if (q.size() > 0) begin
      vectors++;
      miss++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule

// File: doc/circle_motion_ctrl.md
Name: circle_motion_ctrl

Overview:
- Controller that positions and colours the OLED circle sprite.
- Turns debounced push-button presses into a movement state, steps the circle centre one pixel per prescaled tick, and clamps the centre so the whole circle stays on the 96x64 panel.
- Outputs drive the circle renderer's base_x, base_y and colour inputs directly.
- Sits between the button debouncers and the pixel renderer.

Parameters:
- TICK_DIV, 2_000_000: clk cycles per one-pixel step (50 Hz at 100 MHz); must be >= 2.
- RADIUS, 6: circle radius in pixels; sets the clamp margins.
- WIDTH, 96: panel width in pixels.
- HEIGHT, 64: panel height in pixels.
- START_X, 48: reset centre x.
- START_Y, 32: reset centre y.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- btnU  in  1  up button, debounced, synchronous to clk, level
- btnD  in  1  down button, debounced, synchronous to clk, level
- btnL  in  1  left button, debounced, synchronous to clk, level
- btnR  in  1  right button, debounced, synchronous to clk, level
- btnC  in  1  centre button, debounced, synchronous to clk, level
- base_x  out  7  circle centre x, registered
- base_y  out  7  circle centre y, registered
- colour  out  16  RGB565 circle colour, registered
- moving  out  1  high when state is not STOP
- dir  out  3  state encoding: 0 STOP, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT

Behaviour:
- Reset (asynchronous; takes effect immediately, no clock edge needed):
  - base_x=START_X, base_y=START_Y, colour=16'h07E0 (green).
  - state=STOP, tick counter=0, all button-history registers=0.
  - A button already high when reset releases counts as a press on the first clk edge.
- Press detection: press_b = btn_b & ~btn_b_prev. btn_b_prev is registered every cycle, so a held button gives exactly one press.
- Press priority within one cycle: C > U > D > L > R. Only the highest-priority press acts; the others are discarded.
- btnC press:
  - state goes to STOP and the tick counter clears.
  - colour cycles 07E0 -> F800 -> 001F -> FFFF -> 07E0.
- Direction press, target direction different from the current state: state goes to MOVE_<dir> and the tick counter clears to 0 on that edge.
- Direction press, target equal to the current state: ignored; the counter keeps running.
- Direction press toward a wall the circle already touches (e.g. btnR with base_x=MAX_X): ignored; state and counter are unchanged.
- Limits: MIN_X=RADIUS=6, MAX_X=WIDTH-1-RADIUS=89, MIN_Y=RADIUS=6, MAX_Y=HEIGHT-1-RADIUS=57.
- Tick counter:
  - In a MOVE state: counts 0..TICK_DIV-1, then wraps to 0.
  - In STOP: held at 0.
  - The wrap edge is a step edge.
- Step timing: a press sampled at edge k produces the first step at edge k+TICK_DIV, and subsequent steps every TICK_DIV cycles.
- Step action: the centre moves 1 pixel in the state's direction. UP decrements base_y, DOWN increments base_y, LEFT decrements base_x, RIGHT increments base_x.
- Reaching a limit: if the new coordinate equals the limit, state goes to STOP on the same edge, so the centre never passes the limit.
- Press coinciding with a step edge:
  - A direction-changing press or btnC wins: no step occurs, and the counter clears (direction change) or the state stops (btnC).
  - A same-direction press does not interfere: the step occurs.
- Arithmetic: all coordinate arithmetic is 7-bit unsigned; limit checks precede the increment/decrement, so no wrap-around is possible.
- Outputs:
  - moving and dir are decoded from the state register only.
  - No output is combinational from the buttons; latency from a button edge to a moving/dir change is 1 clk.

Test Plan (TICK_DIV=4, other parameters default):
- Reset asserted, then released -> base_x=48, base_y=32, colour=07E0, moving=0, dir=0.
- One-cycle btnR pulse at edge k -> dir=4 after edge k; base_x=49 at edge k+4, 50 at k+8; btnR held high for 20 cycles still gives exactly one press.
- btnR, run until base_x=89 -> moving drops on the same edge base_x becomes 89; base_x stays 89 for 20 more cycles; a further btnR press is ignored (dir stays 0).
- btnC pressed 4 times, one per 3 cycles, during MOVE_RIGHT -> dir=0 after the first press; colour F800, 001F, FFFF, 07E0 in turn; position frozen.
- btnU and btnL rising in the same cycle -> dir=1 (UP); base_y decrements every 4 cycles down to 6, then stop. btnL pressed on a step edge -> no step that cycle, dir=3, next step 4 cycles later.
- reset asserted mid-move between clk edges -> base_x=48, base_y=32, dir=0 immediately, before the next clk edge.
